// File: rtl/lfsr_range_if.sv
// ----------------------------------------------------------------------------
// lfsr_range_if : draw-control and output-stream bundle for lfsr_range
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface lfsr_range_if #(
   parameter int LEN   = 8,
   parameter int OUT_W = 8
);
   logic             en;
   logic [OUT_W-1:0] range;
   logic [LEN-1:0]   lfsr_val;
   logic             lfsr_en;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      rejects;

   modport master (
      output en, range, lfsr_val, out_ready,
      input  lfsr_en, out_data, out_valid, rejects
   );

   modport slave (
      input  en, range, lfsr_val, out_ready,
      output lfsr_en, out_data, out_valid, rejects
   );
endinterface

`default_nettype wire

// File: rtl/lfsr_range.sv
// ----------------------------------------------------------------------------
// lfsr_range : mask-and-reject reduction of LFSR words to [0, range), FIFO out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lfsr_range #(
   parameter int LEN       = 8,
   parameter int OUT_W     = 8,
   parameter int MAX_TRIES = 3,
   parameter int DEPTH     = 4
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   lfsr_range_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   logic [OUT_W-1:0] range_q;
   logic [OUT_W-1:0] mask_q;
   logic [TRY_W-1:0] tries;
   logic [15:0]      rejects;
   logic [OUT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic [LEN-1:0]   word;
   logic [OUT_W-1:0] cand;
   logic [OUT_W-1:0] push_data;
   logic             full;
   logic             valid;
   logic             draw;
   logic             accept;
   logic             last_try;
   logic             push;
   logic             pop;

   // Smallest 2^k-1 covering n-1; n=0 wraps to all-ones so everything passes.
   function automatic logic [OUT_W-1:0] fill_mask(input logic [OUT_W-1:0] n);
      logic [OUT_W-1:0] m;
      m = n - 1'b1;
      for (int s = 1; s < OUT_W; s = s * 2) begin
         m = m | (m >> s);
      end
      return m;
   endfunction

   assign word      = bus.lfsr_val;
   assign full      = (count == CNT_W'(DEPTH));
   assign valid     = (count != '0);
   assign draw      = bus.en & ~full & rst_n;
   assign cand      = word[OUT_W-1:0] & mask_q;
   assign accept    = (range_q == '0) | (cand < range_q);
   assign last_try  = (tries == TRY_W'(MAX_TRIES - 1));
   assign push      = draw & (accept | last_try);
   // A rejected cand lies in [N, 2N-2], so subtracting N stays in range.
   assign push_data = accept ? cand : (cand - range_q);
   assign pop       = valid & bus.out_ready;

   assign bus.lfsr_en   = draw;
   assign bus.out_valid = valid;
   assign bus.out_data  = valid ? mem[rd_ptr] : '0;
   assign bus.rejects   = rejects;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         range_q <= '0;
         mask_q  <= '1;
      end else if (!bus.en) begin
         range_q <= bus.range;
         mask_q  <= fill_mask(bus.range);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tries   <= '0;
         rejects <= '0;
      end else if (draw) begin
         if (push) begin
            tries <= '0;
         end else begin
            tries <= tries + 1'b1;
         end
         if (!accept && (rejects != 16'hFFFF)) begin
            rejects <= rejects + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

`default_nettype wire
